// File: rtl/sopc_mem_arbiter.sv
// Two-master arbiter for the shared single-port data RAM: m0 = fetch (read-only), m1 = load/store.
// Fixed priority with a starvation guard by default; define SOPC_ARB_RR_EN for round-robin.
module sopc_mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m0_req,
  input  logic [ADDR_W-1:0]   m0_addr,
  output logic                m0_gnt,
  output logic                m0_rvalid,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_req,
  input  logic                m1_we,
  input  logic [DATA_W/8-1:0] m1_be,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  output logic                m1_gnt,
  output logic                m1_rvalid,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                mem_ce,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  logic m0_win;
  logic rd_pend_q, rd_pend_d;
  logic rd_owner_q, rd_owner_d;

`ifdef SOPC_ARB_RR_EN
  // rr_last_q = 1 when m0 took the last grant, so the reset value favours m0 first.
  logic rr_last_q, rr_last_d;

  assign m0_win = ~rr_last_q;

  always_comb begin
    rr_last_d = rr_last_q;
    if (m0_gnt)      rr_last_d = 1'b1;
    else if (m1_gnt) rr_last_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rr_last_q <= 1'b0;
    else      rr_last_q <= rr_last_d;
  end
`else
  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);
  logic [3:0] wait_cnt_q, wait_cnt_d;

  assign m0_win = (wait_cnt_q == MAX_WAIT_C);

  always_comb begin
    wait_cnt_d = 4'd0;
    if (m0_req && !m0_gnt)
      wait_cnt_d = (wait_cnt_q == MAX_WAIT_C) ? wait_cnt_q : wait_cnt_q + 4'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wait_cnt_q <= 4'd0;
    else      wait_cnt_q <= wait_cnt_d;
  end
`endif

  // Grants are forced low while reset is held so nothing is accepted during reset.
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (rst) begin
      if (m0_req && m1_req) begin
        m0_gnt = m0_win;
        m1_gnt = ~m0_win;
      end else begin
        m0_gnt = m0_req;
        m1_gnt = m1_req;
      end
    end
  end

  always_comb begin
    mem_ce    = m0_gnt | m1_gnt;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (m0_gnt) begin
      mem_be   = '1;
      mem_addr = m0_addr;
    end else if (m1_gnt) begin
      mem_we    = m1_we;
      mem_be    = m1_be;
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
    end
  end

  always_comb begin
    rd_pend_d  = m0_gnt | (m1_gnt & ~m1_we);
    rd_owner_d = rd_owner_q;
    if (m1_gnt && !m1_we) rd_owner_d = 1'b1;
    else if (m0_gnt)      rd_owner_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_pend_q  <= 1'b0;
      rd_owner_q <= 1'b0;
    end else begin
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  assign m0_rvalid = rd_pend_q & ~rd_owner_q;
  assign m1_rvalid = rd_pend_q &  rd_owner_q;
  assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
  assign m1_rdata  = m1_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_sopc_mem_arbiter.sv
// Directed bench for sopc_mem_arbiter: vector table plus reset, starvation and mid-op reset sequences.
module tb_sopc_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        m0_req;
  logic [31:0] m0_addr;
  logic        m0_gnt;
  logic        m0_rvalid;
  logic [31:0] m0_rdata;
  logic        m1_req;
  logic        m1_we;
  logic [3:0]  m1_be;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic        m1_gnt;
  logic        m1_rvalid;
  logic [31:0] m1_rdata;
  logic        mem_ce;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int n_cmp = 0;
  int n_err = 0;

  sopc_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_gnt(m0_gnt),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_be(m1_be), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        m0_req;
    logic [31:0] m0_addr;
    logic        m1_req;
    logic        m1_we;
    logic [3:0]  m1_be;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic [31:0] mem_rdata;
    logic        e_m0_gnt;
    logic        e_m1_gnt;
    logic        e_m0_rv;
    logic        e_m1_rv;
    logic [31:0] e_m0_rd;
    logic [31:0] e_m1_rd;
    logic        e_ce;
    logic        e_we;
    logic [3:0]  e_be;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
  } vec_t;

  vec_t vecs[8];

  function automatic vec_t mk(
    input logic m0r, input logic [31:0] m0a,
    input logic m1r, input logic m1w, input logic [3:0] m1b,
    input logic [31:0] m1a, input logic [31:0] m1d, input logic [31:0] rd,
    input logic g0, input logic g1, input logic v0, input logic v1,
    input logic [31:0] d0, input logic [31:0] d1,
    input logic ce, input logic we, input logic [3:0] be,
    input logic [31:0] ad, input logic [31:0] wd);
    vec_t v;
    v.m0_req = m0r; v.m0_addr = m0a; v.m1_req = m1r; v.m1_we = m1w; v.m1_be = m1b;
    v.m1_addr = m1a; v.m1_wdata = m1d; v.mem_rdata = rd;
    v.e_m0_gnt = g0; v.e_m1_gnt = g1; v.e_m0_rv = v0; v.e_m1_rv = v1;
    v.e_m0_rd = d0; v.e_m1_rd = d1; v.e_ce = ce; v.e_we = we; v.e_be = be;
    v.e_addr = ad; v.e_wdata = wd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    m0_req = 1'b0; m0_addr = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_be = '0; m1_addr = '0; m1_wdata = '0;
  endtask

  initial begin
    // inputs, then expected: gnt0 gnt1 rv0 rv1 rd0 rd1 ce we be addr wdata
    vecs[0] = mk(1, 32'h10, 0, 0, 4'h0, 0, 0, 32'h0,
                 1, 0, 0, 0, 0, 0, 1, 0, 4'hF, 32'h10, 0);
    vecs[1] = mk(0, 0, 0, 0, 4'h0, 0, 0, 32'hDEADBEEF,
                 0, 0, 1, 0, 32'hDEADBEEF, 0, 0, 0, 4'h0, 0, 0);
    vecs[2] = mk(0, 0, 1, 1, 4'h3, 32'h20, 32'h12345678, 32'h11111111,
                 0, 1, 0, 0, 0, 0, 1, 1, 4'h3, 32'h20, 32'h12345678);
    vecs[3] = mk(1, 32'h20, 0, 0, 4'h0, 0, 0, 32'h22222222,
                 1, 0, 0, 0, 0, 0, 1, 0, 4'hF, 32'h20, 0);
    vecs[4] = mk(0, 0, 1, 0, 4'h0, 32'h30, 32'h99999999, 32'h00005678,
                 0, 1, 1, 0, 32'h00005678, 0, 1, 0, 4'h0, 32'h30, 32'h99999999);
    vecs[5] = mk(1, 32'h40, 0, 0, 4'h0, 0, 0, 32'hA5A5A5A5,
                 1, 0, 0, 1, 0, 32'hA5A5A5A5, 1, 0, 4'hF, 32'h40, 0);
    vecs[6] = mk(0, 0, 0, 0, 4'h0, 0, 0, 32'h0BADF00D,
                 0, 0, 1, 0, 32'h0BADF00D, 0, 0, 0, 4'h0, 0, 0);
    vecs[7] = mk(0, 0, 0, 0, 4'h0, 0, 0, 32'hFFFFFFFF,
                 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0);

    // Reset held with both masters requesting
    rst = 1'b0;
    idle_inputs();
    m0_req = 1'b1; m0_addr = 32'h100;
    m1_req = 1'b1; m1_addr = 32'h200;
    mem_rdata = 32'hCAFEF00D;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("rst%0d.m0_gnt", i), m0_gnt, 0);
      chk($sformatf("rst%0d.m1_gnt", i), m1_gnt, 0);
      chk($sformatf("rst%0d.m0_rvalid", i), m0_rvalid, 0);
      chk($sformatf("rst%0d.m1_rvalid", i), m1_rvalid, 0);
      chk($sformatf("rst%0d.m0_rdata", i), m0_rdata, 0);
      chk($sformatf("rst%0d.m1_rdata", i), m1_rdata, 0);
    end
    rst = 1'b1;
    #1;
`ifdef SOPC_ARB_RR_EN
    chk("post_rst.m0_gnt", m0_gnt, 1);
    chk("post_rst.m1_gnt", m1_gnt, 0);
`else
    chk("post_rst.m0_gnt", m0_gnt, 0);
    chk("post_rst.m1_gnt", m1_gnt, 1);
`endif
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
`ifdef SOPC_ARB_RR_EN
    chk("post_rst.m0_rvalid", m0_rvalid, 1);
    chk("post_rst.m1_rvalid", m1_rvalid, 0);
    chk("post_rst.m0_rdata", m0_rdata, 32'hCAFEF00D);
`else
    chk("post_rst.m0_rvalid", m0_rvalid, 0);
    chk("post_rst.m1_rvalid", m1_rvalid, 1);
    chk("post_rst.m1_rdata", m1_rdata, 32'hCAFEF00D);
`endif
    @(posedge clk); #1;

    // Vector table, one row per cycle
    for (int i = 0; i < 8; i++) begin
      m0_req = vecs[i].m0_req; m0_addr = vecs[i].m0_addr;
      m1_req = vecs[i].m1_req; m1_we = vecs[i].m1_we; m1_be = vecs[i].m1_be;
      m1_addr = vecs[i].m1_addr; m1_wdata = vecs[i].m1_wdata;
      mem_rdata = vecs[i].mem_rdata;
      @(negedge clk);
      chk($sformatf("row%0d.m0_gnt", i), m0_gnt, vecs[i].e_m0_gnt);
      chk($sformatf("row%0d.m1_gnt", i), m1_gnt, vecs[i].e_m1_gnt);
      chk($sformatf("row%0d.m0_rvalid", i), m0_rvalid, vecs[i].e_m0_rv);
      chk($sformatf("row%0d.m1_rvalid", i), m1_rvalid, vecs[i].e_m1_rv);
      chk($sformatf("row%0d.m0_rdata", i), m0_rdata, vecs[i].e_m0_rd);
      chk($sformatf("row%0d.m1_rdata", i), m1_rdata, vecs[i].e_m1_rd);
      chk($sformatf("row%0d.mem_ce", i), mem_ce, vecs[i].e_ce);
      chk($sformatf("row%0d.mem_we", i), mem_we, vecs[i].e_we);
      chk($sformatf("row%0d.mem_be", i), mem_be, vecs[i].e_be);
      chk($sformatf("row%0d.mem_addr", i), mem_addr, vecs[i].e_addr);
      chk($sformatf("row%0d.mem_wdata", i), mem_wdata, vecs[i].e_wdata);
      @(posedge clk); #1;
    end

    // Continuous contention; previous idle rows have cleared the starvation count
    idle_inputs();
    m0_req = 1'b1; m0_addr = 32'h50;
    m1_req = 1'b1; m1_addr = 32'h60;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
`ifdef SOPC_ARB_RR_EN
      chk($sformatf("arb%0d.m0_gnt", k), m0_gnt, (k % 2) == 1);
      chk($sformatf("arb%0d.m1_gnt", k), m1_gnt, (k % 2) == 0);
`else
      chk($sformatf("arb%0d.m0_gnt", k), m0_gnt, (k % 5) == 4);
      chk($sformatf("arb%0d.m1_gnt", k), m1_gnt, (k % 5) != 4);
`endif
      @(posedge clk); #1;
    end
    idle_inputs();
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Reset asserted right after an m1 read is accepted
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h70;
    mem_rdata = 32'h5A5A5A5A;
    @(negedge clk);
    chk("midrst.m1_gnt", m1_gnt, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    chk("midrst.m1_rvalid", m1_rvalid, 0);
    chk("midrst.m1_rdata", m1_rdata, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("midrst_rel%0d.m0_rvalid", k), m0_rvalid, 0);
      chk($sformatf("midrst_rel%0d.m1_rvalid", k), m1_rvalid, 0);
      @(posedge clk); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
